// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rstseq.sv
// Reset sequencer: synchronizes RN release, stretches it, then releases
// NUM_DOM active-low domain resets one after another, GAP cycles apart.
//
// state      | meaning
// ST_HOLD    | RN asserted or release still in the synchronizer
// ST_STRETCH | counting STRETCH cycles before domain 0 is released
// ST_RELEASE | releasing domains 1..NUM_DOM-1, one every GAP cycles
// ST_RUN     | all domains released, READY high
module gf180mcu_fd_sc_mcu9t5v0__rstseq #(
    parameter int SYNC_STAGES = 2,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4,
    parameter int NUM_DOM     = 4
) (
    input  logic               CLK,
    input  logic               RN,
    input  logic               SRST_REQ,
    output logic [NUM_DOM-1:0] RNO,
    output logic               READY,
    output logic               SOFT_CAUSE
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam logic [7:0] STRETCH_LD  = 8'(STRETCH - 1);
    localparam logic [7:0] STRETCH_LD2 = 8'(STRETCH - 2);
    localparam logic [7:0] GAP_LD      = 8'(GAP - 1);
    localparam logic [2:0] LAST_DOM    = 3'(NUM_DOM - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             dom_q, dom_d;
    logic [NUM_DOM-1:0]     rno_q, rno_d;
    logic                   ready_q, ready_d;
    logic                   soft_q, soft_d;
    logic                   fire0;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        rno_d   = rno_q;
        ready_d = 1'b0;
        soft_d  = soft_q;
        fire0   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                // The edge that first sees the synced release already counts as
                // the first stretch cycle, so STRETCH=1 releases domain 0 here.
                if (sync_q[SYNC_STAGES-1]) begin
                    if (STRETCH == 1) begin
                        fire0 = 1'b1;
                    end else begin
                        state_d = ST_STRETCH;
                        cnt_d   = STRETCH_LD2;
                    end
                end
            end
            ST_STRETCH: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    fire0 = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    for (int i = 1; i < NUM_DOM; i++) begin
                        if (dom_q == 3'(i)) begin
                            rno_d[i] = 1'b1;
                        end
                    end
                    if (dom_q == LAST_DOM) begin
                        state_d = ST_RUN;
                    end else begin
                        dom_d = dom_q + 3'd1;
                        cnt_d = GAP_LD;
                    end
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (fire0) begin
            rno_d[0] = 1'b1;
            if (NUM_DOM == 1) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_RELEASE;
                cnt_d   = GAP_LD;
                dom_d   = 3'd1;
            end
        end

        if (SRST_REQ && (state_q != ST_HOLD)) begin
            state_d = ST_STRETCH;
            cnt_d   = STRETCH_LD;
            dom_d   = 3'd0;
            rno_d   = '0;
            ready_d = 1'b0;
            soft_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            sync_q  <= '0;
            state_q <= ST_HOLD;
            cnt_q   <= 8'd0;
            dom_q   <= 3'd0;
            rno_q   <= '0;
            ready_q <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            rno_q   <= rno_d;
            ready_q <= ready_d;
            soft_q  <= soft_d;
        end
    end

    assign RNO        = rno_q;
    assign READY      = ready_q;
    assign SOFT_CAUSE = soft_q;

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__rstseq.md
GF180MCU_FD_SC_MCU9T5V0__RSTSEQ -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__rstseq

Interface
REQ-001 The block SHALL have one clock, CLK, and one reset, RN, which is asynchronous and active-low.
REQ-002 Parameter SYNC_STAGES, default 2: number of reset-deassertion synchronizer flops; legal range 2..4.
REQ-003 Parameter STRETCH, default 16: cycles from synchronized release to release of domain 0; legal range 1..255.
REQ-004 Parameter GAP, default 4: cycles between releases of consecutive domains; legal range 1..255.
REQ-005 Parameter NUM_DOM, default 4: number of sequenced reset outputs; legal range 1..8.
REQ-006 Port CLK  input  1  clock; all state advances on its rising edge.
REQ-007 Port RN  input  1  raw asynchronous active-low reset.
REQ-008 Port SRST_REQ  input  1  soft-reset request; synchronous to CLK; active-high.
REQ-009 Port RNO  output  NUM_DOM  sequenced active-low domain resets; bit i drives domain i.
REQ-010 Port READY  output  1  high when all domains are released.
REQ-011 Port SOFT_CAUSE  output  1  1 = last reset was soft; 0 = last reset was RN.

Function
REQ-012 RNO, READY, and SOFT_CAUSE SHALL each be driven directly by a flop; no combinational path SHALL exist from any input to any output.
REQ-013 Assertion of RN SHALL clear the synchronizer asynchronously, without waiting for a CLK edge.
REQ-014 Assertion of RN SHALL drive every RNO bit low and READY low asynchronously, without waiting for a CLK edge.
REQ-015 RN deassertion SHALL pass through the SYNC_STAGES-flop chain; the synchronized release is first seen high after edge SYNC_STAGES.
- Edge 1 is the first rising CLK edge after RN rises.
REQ-016 The FSM states SHALL be HOLD, STRETCH, RELEASE, and RUN.
- HOLD: entered on RN low; exits to STRETCH when the synchronized release is high.
- STRETCH: counts STRETCH cycles; then sets RNO[0]=1 and enters RELEASE.
- RELEASE: counts GAP cycles per domain and sets RNO[i]=1 in index order; after RNO[NUM_DOM-1] is set, enters RUN.
- RUN: READY=1; holds.
REQ-017 Release timing after RN deassertion SHALL be:
- RNO[0] rises at edge SYNC_STAGES+STRETCH.
- RNO[i] rises at edge SYNC_STAGES+STRETCH+i*GAP.
- READY rises one edge after RNO[NUM_DOM-1].
REQ-018 Once RNO[i] is released, it SHALL stay high until the next reset event; releases SHALL be monotonic, and a lower index SHALL never be released later than a higher index.
REQ-019 The cycle counter SHALL be 8 bits and SHALL reload on each phase entry; it SHALL never wrap.
REQ-020 SRST_REQ sampled high at edge e in STRETCH, RELEASE, or RUN SHALL drive RNO all low and READY low after edge e, set SOFT_CAUSE=1, and restart STRETCH.
REQ-021 If SRST_REQ is low from edge e+1 onward, RNO[0] SHALL rise at edge e+STRETCH, followed by the REQ-017 GAP spacing.
REQ-022 SRST_REQ held high SHALL keep the block in STRETCH with the counter reloaded each cycle.
REQ-023 SRST_REQ SHALL be ignored in HOLD.
REQ-024 RN asserted at any time SHALL take priority over SRST_REQ and over any in-progress sequence.
REQ-025 If RN is asserted and SRST_REQ is sampled high in the same cycle, RN SHALL win and SOFT_CAUSE SHALL be 0.
REQ-026 With NUM_DOM=1, READY SHALL rise one edge after RNO[0] and RELEASE SHALL take zero GAP cycles.
REQ-027 Reset pulses on RN shorter than one CLK period SHALL still produce a full sequence.

Reset
REQ-028 While RN=0, the outputs SHALL be RNO all 0, READY=0, SOFT_CAUSE=0, state HOLD, counter=0, and synchronizer all 0.
REQ-029 No flop in the block SHALL use a synchronous reset for RN; SRST_REQ handling SHALL be purely synchronous.

Verification
REQ-030 Default parameters, RN released -> RNO=0001 at edge 18, 0011 at 22, 0111 at 26, 1111 at 30; READY=1 at edge 31; SOFT_CAUSE=0.
REQ-031 In RUN, SRST_REQ pulsed for 1 cycle at edge e -> RNO=0000 and READY=0 after e, SOFT_CAUSE=1; RNO[0] rises at e+16 and READY rises at e+29.
REQ-032 RN asserted mid-RELEASE (RNO=0011) between edges -> RNO=0000 immediately, before the next edge; SOFT_CAUSE=0; after RN rises, the full 18/22/26/30 sequence repeats.
REQ-033 SRST_REQ held high for 10 cycles during STRETCH -> no RNO bit rises; RNO[0] rises 16 edges after the last high sample.
REQ-034 NUM_DOM=1, STRETCH=1, GAP=1, SYNC_STAGES=2 -> RNO[0] rises at edge 3 and READY rises at edge 4.
REQ-035 RN and SRST_REQ asserted in the same cycle -> SOFT_CAUSE=0 and the sequence times from RN release.
